// File: rtl/ahb_mem_slave_param.sv
// AHB-Lite leaf memory slave: parametrised width/depth, programmable wait states,
// INCR/WRAPx/INCRx burst address tracking and two-cycle ERROR responses.
module ahb_mem_slave_param #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned SLAVE_ID    = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 1
) (
  input  logic                    h_clk,
  input  logic                    h_resetn,
  input  logic [ADDR_WIDTH-1:0]   h_addr,
  input  logic [2:0]              h_burst,
  input  logic [2:0]              h_size,
  input  logic [1:0]              h_trans,
  input  logic [DATA_WIDTH-1:0]   h_wdata,
  input  logic [DATA_WIDTH/8-1:0] h_wstrb,
  input  logic                    h_write,
  output logic [DATA_WIDTH-1:0]   h_rdata,
  output logic                    h_ready,
  output logic                    h_resp
);
  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned LB     = $clog2(BPW);
  localparam int unsigned NWORDS = (2 ** OFFSET_BITS) / BPW;
  localparam int unsigned WW     = OFFSET_BITS - LB;
  localparam int unsigned HW     = ADDR_WIDTH - OFFSET_BITS;
  localparam logic [HW-1:0] SID      = HW'(SLAVE_ID);
  localparam logic [WW-1:0] RO_FIRST = WW'(NWORDS - RO_WORDS);
  localparam logic [2:0]    MAX_SIZE = 3'(LB);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, state_nx;

  logic [OFFSET_BITS-1:0] addr_q;
  logic [2:0]             size_q;
  logic                   wr_q;
  logic [2:0]             wcnt;
  logic                   burst_act, burst_wrap, burst_fixed;
  logic [4:0]             beats_left;
  logic [ADDR_WIDTH-1:0]  burst_mask, exp_addr;
  logic [DATA_WIDTH-1:0]  mem [NWORDS];

  logic                  accept, is_seq, err, cur_wrap;
  logic [LB-1:0]         align_mask;
  logic [WW-1:0]         a_word;
  logic [ADDR_WIDTH-1:0] inc, new_mask, cur_mask, nxt_addr;
  logic [BPW-1:0]        lane;

  always_comb begin
    accept = ((state == S_IDLE) || (state == S_DATA)) && h_trans[1];
    is_seq = h_trans[0];
    a_word = h_addr[OFFSET_BITS-1:LB];
    align_mask = '0;
    for (int unsigned i = 0; i < LB; i++) align_mask[i] = (i < 32'(h_size));
    err = 1'b0;
    if (h_addr[ADDR_WIDTH-1:OFFSET_BITS] != SID)                  err = 1'b1;
    else if (h_size > MAX_SIZE)                                   err = 1'b1;
    else if (|(h_addr[LB-1:0] & align_mask))                      err = 1'b1;
    else if (is_seq && (!burst_act || (h_addr != exp_addr)))      err = 1'b1;
    else if (is_seq && burst_fixed && (beats_left == '0))         err = 1'b1;
    else if (h_write && (RO_WORDS != 0) && (a_word >= RO_FIRST))  err = 1'b1;
    // Wrap window is beats x transfer size; beats = 2 << h_burst[2:1] gives 4/8/16.
    inc      = ADDR_WIDTH'(1) << h_size;
    new_mask = ((ADDR_WIDTH'(2) << h_burst[2:1]) << h_size) - ADDR_WIDTH'(1);
    cur_wrap = is_seq ? burst_wrap : ((h_burst != 3'b000) && !h_burst[0]);
    cur_mask = is_seq ? burst_mask : new_mask;
    nxt_addr = cur_wrap ? ((h_addr & ~cur_mask) | ((h_addr + inc) & cur_mask))
                        : (h_addr + inc);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DATA: begin
        if (!accept)                state_nx = S_IDLE;
        else if (err)               state_nx = S_ERR1;
        else if (WAIT_STATES > 0)   state_nx = S_WAIT;
        else                        state_nx = S_DATA;
      end
      S_WAIT:  if (wcnt == 3'd1) state_nx = S_DATA;
      S_ERR1:  state_nx = S_ERR2;
      S_ERR2:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    h_ready = !((state == S_WAIT) || (state == S_ERR1));
    h_resp  = (state == S_ERR1) || (state == S_ERR2);
    h_rdata = (state == S_DATA) ? mem[addr_q[OFFSET_BITS-1:LB]] : '0;
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      wr_q        <= 1'b0;
      burst_act   <= 1'b0;
      burst_wrap  <= 1'b0;
      burst_fixed <= 1'b0;
      beats_left  <= '0;
      burst_mask  <= '0;
      exp_addr    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT) wcnt <= wcnt - 3'd1;
      if (accept) begin
        addr_q <= h_addr[OFFSET_BITS-1:0];
        size_q <= h_size;
        wr_q   <= h_write;
        wcnt   <= 3'(WAIT_STATES);
      end
      if (state == S_ERR2) begin
        burst_act <= 1'b0;
      end else if (accept && !err) begin
        exp_addr <= nxt_addr;
        if (!is_seq) begin
          burst_act   <= (h_burst != 3'b000);
          burst_wrap  <= cur_wrap;
          burst_fixed <= (h_burst != 3'b001);
          beats_left  <= (5'd2 << h_burst[2:1]) - 5'd1;
          burst_mask  <= new_mask;
        end else if (burst_fixed) begin
          beats_left <= beats_left - 5'd1;
        end
      end
    end
  end

  always_comb begin
    lane = '0;
    for (int unsigned b = 0; b < BPW; b++)
      lane[b] = (b >= 32'(addr_q[LB-1:0])) &&
                (b < 32'(addr_q[LB-1:0]) + (32'd1 << size_q));
  end

  // Commit happens on the edge that ends DATA; an async reset drops state first.
  always_ff @(posedge h_clk) begin
    if ((state == S_DATA) && wr_q)
      for (int unsigned b = 0; b < BPW; b++)
        if (h_wstrb[b] && lane[b])
          mem[addr_q[OFFSET_BITS-1:LB]][8*b +: 8] <= h_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_ahb_mem_slave_param.sv
// Scoreboard bench: one zero-wait and one three-wait-state slave share the bus signals;
// sel routes transfers to one of them and picks which outputs the monitor observes.
module tb_ahb_mem_slave_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst3_n;
  logic [31:0] h_addr, h_wdata;
  logic [2:0]  h_burst, h_size;
  logic [1:0]  h_trans, trans0, trans3;
  logic [3:0]  h_wstrb;
  logic        h_write;
  logic [31:0] rdata0, rdata3, rdata;
  logic        ready0, ready3, ready, resp0, resp3, resp;
  bit          sel = 1'b0;

  assign trans0 = sel ? 2'b00 : h_trans;
  assign trans3 = sel ? h_trans : 2'b00;
  assign ready  = sel ? ready3 : ready0;
  assign resp   = sel ? resp3  : resp0;
  assign rdata  = sel ? rdata3 : rdata0;

  ahb_mem_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .OFFSET_BITS(6), .SLAVE_ID(2),
                        .WAIT_STATES(0), .RO_WORDS(1)) dut0 (
    .h_clk(clk), .h_resetn(rst0_n), .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size),
    .h_trans(trans0), .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_write(h_write),
    .h_rdata(rdata0), .h_ready(ready0), .h_resp(resp0));

  ahb_mem_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .OFFSET_BITS(6), .SLAVE_ID(2),
                        .WAIT_STATES(3), .RO_WORDS(1)) dut3 (
    .h_clk(clk), .h_resetn(rst3_n), .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size),
    .h_trans(trans3), .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_write(h_write),
    .h_rdata(rdata3), .h_ready(ready3), .h_resp(resp3));

  typedef struct {
    string       tag;
    bit          err;
    bit          rd;
    logic [31:0] exp;
    logic [31:0] msk;
    bit          ne;
    logic [31:0] nev;
    int unsigned waits;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mdl [2][64];
  bit          kv  [2][64];
  int unsigned n_chk = 0, n_fail = 0;
  bit          mon_en = 1'b0;
  bit          dp_active = 1'b0;
  int unsigned waits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   acc;
    if (!mon_en) begin
      dp_active = 1'b0;
      waits     = 0;
    end else begin
      acc = ready && !resp && h_trans[1];
      if (dp_active) begin
        if (!ready) begin
          waits++;
          if (sb.size() > 0) check({sb[0].tag, "_wresp"}, 32'(resp), 32'(sb[0].err));
        end else if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
          dp_active = 1'b0;
        end else begin
          e = sb.pop_front();
          check({e.tag, "_resp"}, 32'(resp), 32'(e.err));
          check({e.tag, "_waits"}, waits, e.waits);
          if (e.err) check({e.tag, "_erdata"}, rdata, 32'd0);
          if (e.rd && !e.err) check({e.tag, "_rdata"}, rdata & e.msk, e.exp & e.msk);
          if (e.ne) check({e.tag, "_ro_kept"}, 32'(rdata === e.nev), 32'd0);
          dp_active = 1'b0;
        end
      end
      if (acc) begin
        dp_active = 1'b1;
        waits     = 0;
      end
    end
  end

  task automatic xfer(input string tag, input logic [1:0] tr, input logic [2:0] up,
                      input logic [5:0] off, input logic [2:0] sz, input logic [2:0] bu,
                      input logic wr, input logic [31:0] wd, input logic [3:0] ws,
                      input bit eerr, input bit ne);
    exp_t        e;
    int unsigned s, lo, n, base;
    bit          ok;
    s    = sel ? 1 : 0;
    lo   = 32'(off[1:0]);
    n    = 32'd1 << sz;
    base = 32'(off) & 32'h3C;
    e.tag = tag; e.err = eerr; e.rd = !wr; e.ne = ne; e.nev = wd;
    e.waits = eerr ? 1 : (sel ? 3 : 0);
    e.exp = '0; e.msk = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr && !eerr && (b >= lo) && (b < lo + n) && ws[b]) begin
        mdl[s][base + b] = wd[8*b +: 8];
        kv[s][base + b]  = 1'b1;
      end
      e.exp[8*b +: 8] = mdl[s][base + b];
      e.msk[8*b +: 8] = kv[s][base + b] ? 8'hFF : 8'h00;
    end
    sb.push_back(e);
    h_trans = tr; h_addr = (32'(up) << 6) | 32'(off);
    h_size = sz; h_burst = bu; h_write = wr;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready && !resp) begin ok = 1'b1; break; end
    end
    check({tag, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    h_trans = 2'b00; h_wdata = wd; h_wstrb = ws;
  endtask

  task automatic busy();
    h_trans = 2'b01;
    @(posedge clk); #1;
    h_trans = 2'b00;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (sb.size() == 0 && !dp_active) begin done = 1'b1; break; end
    end
    check("drain", 32'(done), 32'd1);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) for (int i = 0; i < 64; i++) begin
      mdl[s][i] = 8'h00; kv[s][i] = 1'b0;
    end
    rst0_n = 1'b0; rst3_n = 1'b0;
    h_addr = '0; h_burst = '0; h_size = '0; h_trans = '0;
    h_wdata = '0; h_wstrb = '0; h_write = 1'b0;
    #12;
    check("rst0_ready", 32'(ready0), 32'd1);
    check("rst0_resp",  32'(resp0),  32'd0);
    check("rst0_rdata", rdata0,      32'd0);
    check("rst3_ready", 32'(ready3), 32'd1);
    check("rst3_resp",  32'(resp3),  32'd0);
    check("rst3_rdata", rdata3,      32'd0);
    @(posedge clk); #1;
    rst0_n = 1'b1; rst3_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    // zero-wait slave
    xfer("wr08",   2'b10, 3'd2, 6'h08, 3'd2, 3'd0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    xfer("rd08",   2'b10, 3'd2, 6'h08, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("size6",  2'b10, 3'd2, 6'h00, 3'd6, 3'd0, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    xfer("hw0A",   2'b10, 3'd2, 6'h0A, 3'd1, 3'd0, 1'b1, 32'hAAAA5555, 4'hF, 1'b0, 1'b0);
    xfer("rd08b",  2'b10, 3'd2, 6'h08, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("decode", 2'b10, 3'd3, 6'h08, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    xfer("ro_wr",  2'b10, 3'd2, 6'h3C, 3'd2, 3'd0, 1'b1, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    xfer("ro_rd",  2'b10, 3'd2, 6'h3C, 3'd2, 3'd0, 1'b0, 32'hCAFEF00D, 4'h0, 1'b0, 1'b1);
    xfer("incr10", 2'b10, 3'd2, 6'h10, 3'd2, 3'd1, 1'b1, 32'h01010101, 4'hF, 1'b0, 1'b0);
    busy();
    xfer("incr14", 2'b11, 3'd2, 6'h14, 3'd2, 3'd1, 1'b1, 32'h02020202, 4'hF, 1'b0, 1'b0);
    xfer("seq16",  2'b11, 3'd2, 6'h16, 3'd2, 3'd1, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    xfer("seq18",  2'b11, 3'd2, 6'h18, 3'd2, 3'd1, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    xfer("rd10",   2'b10, 3'd2, 6'h10, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("rd14",   2'b10, 3'd2, 6'h14, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("wrap38", 2'b10, 3'd2, 6'h38, 3'd2, 3'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("wrap3C", 2'b11, 3'd2, 6'h3C, 3'd2, 3'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("wrap30", 2'b11, 3'd2, 6'h30, 3'd2, 3'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("wrap34", 2'b11, 3'd2, 6'h34, 3'd2, 3'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("wrap5",  2'b11, 3'd2, 6'h38, 3'd2, 3'd2, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    drain();

    // three-wait-state slave
    sel = 1'b1;
    @(posedge clk); #1;
    xfer("w3wr20", 2'b10, 3'd2, 6'h20, 3'd2, 3'd0, 1'b1, 32'h11223344, 4'hF, 1'b0, 1'b0);
    xfer("w3rd20", 2'b10, 3'd2, 6'h20, 3'd2, 3'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0);
    xfer("w3size", 2'b10, 3'd2, 6'h20, 3'd3, 3'd0, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0);
    drain();

    // reset pulse while a write sits in WAIT
    mon_en = 1'b0;
    h_trans = 2'b10; h_addr = 32'h0000_00A0; h_size = 3'd2; h_burst = 3'd0; h_write = 1'b1;
    @(posedge clk); #1;
    h_trans = 2'b00; h_wdata = 32'h55667788; h_wstrb = 4'hF;
    check("w3_in_wait", 32'(ready3), 32'd0);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    check("w3_rst_ready", 32'(ready3), 32'd1);
    check("w3_rst_resp",  32'(resp3),  32'd0);
    check("w3_rst_rdata", rdata3,      32'd0);
    @(posedge clk); #1;
    rst3_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    xfer("w3rd20b", 2'b10, 3'd2, 6'h20, 3'd2, 3'd0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ahb_mem_slave_param.md
Name: ahb_mem_slave_param

Overview:
Parametrised AHB-Lite memory slave; the next generation of the team's AHB_slave. Adds configurable data width, memory depth, programmable wait states, burst-address tracking for INCR/WRAPx/INCRx bursts, and the full AHB two-cycle error response. It sits behind the AHB interconnect as a leaf slave and is address-decoded on the upper address bits.

Parameters:
DATA_WIDTH, 32, data bus width in bits; 32 or 64 only.
ADDR_WIDTH, 32, address bus width.
OFFSET_BITS, 6, low address bits forming the byte offset inside the slave; memory holds 2^OFFSET_BITS bytes.
SLAVE_ID, 2, value h_addr[ADDR_WIDTH-1:OFFSET_BITS] must equal for a hit.
WAIT_STATES, 0, h_ready-low cycles inserted before each OKAY data phase; 0..7.
RO_WORDS, 1, number of topmost memory words that are read-only.

Ports:
h_clk  in  1  clock
h_resetn  in  1  asynchronous active-low reset
h_addr  in  ADDR_WIDTH  address-phase address
h_burst  in  3  HBURST encoding
h_size  in  3  HSIZE encoding
h_trans  in  2  00 idle, 01 busy, 10 nonseq, 11 seq
h_wdata  in  DATA_WIDTH  write data, valid in the data phase
h_wstrb  in  DATA_WIDTH/8  byte write strobes, valid in the data phase
h_write  in  1  1 = write
h_rdata  out  DATA_WIDTH  read data
h_ready  out  1  transfer-done / slave ready
h_resp  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset is asynchronous on h_resetn low. Outputs on reset: h_ready=1, h_resp=0, h_rdata=0. FSM goes to IDLE and burst tracking is cleared. Memory contents are not reset.
- Address phase is accepted only on a rising edge with h_ready=1 and h_trans in {NONSEQ, SEQ}. The slave then latches addr, size, write and burst.
- IDLE and BUSY transfers give a zero-wait OKAY (h_ready=1, h_resp=0). BUSY does not advance the burst.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE → WAIT when a valid transfer is accepted and WAIT_STATES>0.
  - IDLE → DATA when a valid transfer is accepted and WAIT_STATES=0.
  - IDLE → ERR1 when an errored transfer is accepted.
  - WAIT: h_ready=0 and a counter decrements. Go to DATA when the counter reaches 1.
  - DATA: h_ready=1, h_resp=0. A write commits at the end of this cycle. A new address phase can be accepted in the same cycle (pipelined).
  - ERR1: h_ready=0, h_resp=1. Always → ERR2.
  - ERR2: h_ready=1, h_resp=1. The transfer offered in this cycle is ignored and not accepted. Burst tracking is cleared. → IDLE.
- Error conditions, checked at the address phase in this priority order:
  1. decode miss;
  2. h_size > log2(DATA_WIDTH/8);
  3. address not aligned to h_size;
  4. SEQ with no burst active, or SEQ address ≠ expected next address;
  5. SEQ beyond the beat count of a fixed-length burst;
  6. write with the addressed word in the top RO_WORDS words.
  No wait states are inserted before an error response.
- Burst tracking:
  - NONSEQ with h_burst≠SINGLE starts a burst, with beats left = 4/8/16 for WRAPx/INCRx, or unbounded for INCR.
  - Expected next address = addr + 2^size.
  - For WRAPx the wrap boundary is beats×2^size: keep the high bits and wrap the low bits.
  - A NONSEQ while a burst is active starts a new burst; this is not an error.
- Write: effective byte enable = h_wstrb AND the lane mask derived from size and addr low bits. Lanes outside the mask are never written.
- Read: h_rdata is driven from memory at the latched address during DATA and is combinational from the array, so a read whose data phase follows a write's data phase to the same address returns the new data. h_rdata=0 in all other states.
- Reset asserted mid-transfer aborts it; a partially completed write is not committed.

Test Plan:
- SLAVE_ID=2, WAIT_STATES=0: write 0xDEADBEEF at offset 0x08 (size 010, strobe 1111), then read 0x08 → rdata 0xDEADBEEF; each data phase has h_ready=1, h_resp=0.
- Size error and partial strobes: size 110 → ERR1 (ready 0, resp 1) then ERR2 (ready 1, resp 1). Halfword write 0xAAAA5555 at 0x0A, strobe 1111 → only bytes 2–3 change.
- Decode and read-only errors: address upper bits 3 → two-cycle error. Write to 0x3C (RO_WORDS=1) → two-cycle error and memory unchanged; a read of 0x3C → OKAY.
- INCR burst: NONSEQ 0x10, BUSY, SEQ 0x14 → OKAY. Next SEQ 0x16 → two-cycle error, and the following SEQ 0x18 also errors because no burst is active.
- WRAP4 word burst starting at 0x38: addresses 0x38, 0x3C, 0x30, 0x34 accepted (reads); a fifth SEQ → error.
- WAIT_STATES=3: each OKAY data phase shows exactly 3 cycles of h_ready=0. h_resetn pulsed low during WAIT of a write → h_ready=1 immediately and the target word is unchanged.
